// File: rtl/vga_pmod_timing.sv
// VGA timing generator with colour-depth expansion and TinyTapeout PMOD pin mapping.
// The pinout select is latched only at the frame boundary so a mode change never tears the image.
module vga_pmod_timing #(
    parameter int   H_VIS    = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_VIS    = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0,
    parameter int   CBITS    = 4,
    parameter int   CW       = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode_in,
    input  logic [CBITS-1:0] r_in,
    input  logic [CBITS-1:0] g_in,
    input  logic [CBITS-1:0] b_in,
    output logic [CW-1:0]    x,
    output logic [CW-1:0]    y,
    output logic             de,
    output logic             frame_start,
    output logic [7:0]       uo_out,
    output logic [7:0]       uio_out,
    output logic [7:0]       uio_oe
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS_C  = CW'(H_VIS);
    localparam logic [CW-1:0] V_VIS_C  = CW'(V_VIS);
    localparam logic [CW-1:0] HS_START = CW'(H_VIS + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_VIS + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_START = CW'(V_VIS + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_VIS + V_FP + V_SYNC);

    // Left-justify a CBITS-wide channel into 4 bits, repeating its MSBs into the low bits.
    function automatic logic [3:0] expand(input logic [CBITS-1:0] c);
        logic [3:0] e;
        e = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            e[3-i] = c[CBITS-1-(i % CBITS)];
        end
        return e;
    endfunction

    logic [CW-1:0] h_r;
    logic [CW-1:0] v_r;
    logic          mode_r;
    logic [3:0]    r4_r;
    logic [3:0]    g4_r;
    logic [3:0]    b4_r;
    logic          hs_r;
    logic          vs_r;

    logic          h_last_s;
    logic          v_last_s;
    logic          de_s;
    logic          hs_raw_s;
    logic          vs_raw_s;

    assign h_last_s    = (h_r == H_LAST);
    assign v_last_s    = (v_r == V_LAST);
    assign de_s        = (h_r < H_VIS_C) && (v_r < V_VIS_C);
    assign hs_raw_s    = (h_r >= HS_START) && (h_r < HS_END);
    assign vs_raw_s    = (v_r >= VS_START) && (v_r < VS_END);

    assign x           = h_r;
    assign y           = v_r;
    assign de          = de_s;
    assign frame_start = (h_r == '0) && (v_r == '0);

    // Horizontal and vertical raster counters; v advances only on the h wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_r <= '0;
            v_r <= '0;
        end else if (h_last_s) begin
            h_r <= '0;
            if (v_last_s) begin
                v_r <= '0;
            end else begin
                v_r <= v_r + CW'(1);
            end
        end else begin
            h_r <= h_r + CW'(1);
        end
    end

    // Pinout select: follows mode_in in reset, otherwise only on the last pixel of a frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_r <= mode_in;
        end else if (h_last_s && v_last_s) begin
            mode_r <= mode_in;
        end else begin
            mode_r <= mode_r;
        end
    end

    // Output stage: blanked colour plus syncs for the same h/v, keeping them aligned.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r4_r <= 4'h0;
            g4_r <= 4'h0;
            b4_r <= 4'h0;
            hs_r <= ~SYNC_POL;
            vs_r <= ~SYNC_POL;
        end else begin
            r4_r <= de_s ? expand(r_in) : 4'h0;
            g4_r <= de_s ? expand(g_in) : 4'h0;
            b4_r <= de_s ? expand(b_in) : 4'h0;
            hs_r <= hs_raw_s ? SYNC_POL : ~SYNC_POL;
            vs_r <= vs_raw_s ? SYNC_POL : ~SYNC_POL;
        end
    end

    // Pin mapping for single-PMOD (2-bit) or Digilent dual-PMOD (4-bit) boards.
    always_comb begin
        uo_out  = 8'h00;
        uio_out = 8'h00;
        uio_oe  = 8'h00;
        if (mode_r) begin
            uo_out  = {hs_r, b4_r[2], g4_r[2], r4_r[2], vs_r, b4_r[3], g4_r[3], r4_r[3]};
            uio_out = 8'h00;
            uio_oe  = 8'h00;
        end else begin
            uo_out  = {b4_r, r4_r};
            uio_out = {2'b00, vs_r, hs_r, g4_r};
            uio_oe  = 8'hFF;
        end
    end

endmodule

// File: tb/tb_vga_pmod_timing.sv
// Directed bench for vga_pmod_timing on a 16x8 raster: a 4-bit-colour instance
// plus a 2-bit-colour instance held in single-PMOD mode.
module tb_vga_pmod_timing;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mode_in;
    logic       mode2;
    logic [3:0] r_in, g_in, b_in;
    logic [1:0] r2, g2, b2;
    logic [3:0] x, y, x2, y2;
    logic       de, frame_start, de2, frame_start2;
    logic [7:0] uo_out, uio_out, uio_oe, uo2, uio2, oe2;

    int checks = 0;
    int errors = 0;

    vga_pmod_timing #(.H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_VIS(4), .V_FP(1),
                      .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0), .CBITS(4), .CW(4)) dut (
        .clk(clk), .rst_n(rst_n), .mode_in(mode_in), .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .x(x), .y(y), .de(de), .frame_start(frame_start),
        .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe));

    vga_pmod_timing #(.H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_VIS(4), .V_FP(1),
                      .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0), .CBITS(2), .CW(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .mode_in(mode2), .r_in(r2), .g_in(g2), .b_in(b2),
        .x(x2), .y(y2), .de(de2), .frame_start(frame_start2),
        .uo_out(uo2), .uio_out(uio2), .uio_oe(oe2));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp_v, $time);
        end
    endtask

    task automatic wait_xy(input logic [3:0] tx, input logic [3:0] ty);
        int n;
        n = 0;
        while (!(x == tx && y == ty) && n < 300) begin
            step();
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL wait_xy: timeout waiting for (%0d,%0d), got (%0d,%0d)", tx, ty, x, y);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mode_in = 1'b0;
        step(); step();
        chk("rst0_uo", uo_out, 8'h00);
        chk("rst0_uio", uio_out, 8'h30);
        chk("rst0_oe", uio_oe, 8'hFF);
        chk("rst0_x", {4'h0, x}, 8'h00);
        chk("rst0_y", {4'h0, y}, 8'h00);
        chk("rst0_fs", {7'h0, frame_start}, 8'h01);
        chk("rst0_de", {7'h0, de}, 8'h01);
        mode_in = 1'b1;
        step();
        chk("rst1_uo", uo_out, 8'h88);
        chk("rst1_uio", uio_out, 8'h00);
        chk("rst1_oe", uio_oe, 8'h00);
        mode_in = 1'b0;
        step();
        chk("rst_back_oe", uio_oe, 8'hFF);
    endtask

    task automatic test_counter_sweep();
        int de_cnt, vs_cnt, ph, pv;
        logic exp_de, exp_hs;
        de_cnt = 0; vs_cnt = 0;
        rst_n = 1'b1;
        for (int i = 0; i <= 128; i++) begin
            exp_de = ((i % 16) < 8) && (((i / 16) % 8) < 4);
            chk("sweep_x", {4'h0, x}, 8'(i % 16));
            chk("sweep_y", {4'h0, y}, 8'((i / 16) % 8));
            chk("sweep_de", {7'h0, de}, {7'h0, exp_de});
            chk("sweep_fs", {7'h0, frame_start}, {7'h0, (i == 0 || i == 128)});
            if (de && i < 128) de_cnt++;
            if (i > 0) begin
                ph = (i - 1) % 16;
                pv = (i - 1) / 16;
                exp_hs = !(ph >= 10 && ph <= 12);
                chk("sweep_hs_pin", {7'h0, uio_out[4]}, {7'h0, exp_hs});
                chk("sweep_vs_pin", {7'h0, uio_out[5]}, {7'h0, !(pv == 5 || pv == 6)});
                if (!uio_out[5]) vs_cnt++;
            end
            if (i < 128) step();
        end
        chk("sweep_de_count", 8'(de_cnt), 8'd32);
        chk("sweep_vs_count", 8'(vs_cnt), 8'd32);
    endtask

    task automatic test_colour_mode0();
        wait_xy(4'd2, 4'd1);
        r_in = 4'hA; g_in = 4'h5; b_in = 4'h3;
        step();
        chk("col0_uo", uo_out, 8'h3A);
        chk("col0_uio", uio_out, 8'h35);
        wait_xy(4'd9, 4'd1);
        step();
        chk("col0_blank_uo", uo_out, 8'h00);
        chk("col0_blank_uio", uio_out, 8'h30);
        r_in = 4'h0; g_in = 4'h0; b_in = 4'h0;
    endtask

    task automatic test_depth();
        wait_xy(4'd3, 4'd2);
        r2 = 2'b10; g2 = 2'b01; b2 = 2'b11;
        step();
        chk("depth_uo", uo2, 8'hED);
        chk("depth_uio", uio2, 8'h00);
        chk("depth_oe", oe2, 8'h00);
        chk("depth_x", {4'h0, x2}, 8'h04);
        chk("depth_y", {4'h0, y2}, 8'h02);
        chk("depth_de", {7'h0, de2}, 8'h01);
        chk("depth_fs", {7'h0, frame_start2}, 8'h00);
        r2 = 2'b00; g2 = 2'b00; b2 = 2'b00;
    endtask

    task automatic test_mode_switch();
        mode_in = 1'b1;
        step();
        chk("msw_early_oe", uio_oe, 8'hFF);
        wait_xy(4'd15, 4'd7);
        chk("msw_wrap_oe", uio_oe, 8'hFF);
        step();
        chk("msw_new_oe", uio_oe, 8'h00);
        chk("msw_new_uio", uio_out, 8'h00);
        wait_xy(4'd4, 4'd1);
        mode_in = 1'b0;
        step(); step();
        chk("msw_glitch_oe", uio_oe, 8'h00);
        mode_in = 1'b1;
        wait_xy(4'd15, 4'd7);
        step();
        chk("msw_after_glitch_oe", uio_oe, 8'h00);
    endtask

    task automatic test_colour_mode1();
        wait_xy(4'd2, 4'd1);
        r_in = 4'hA; g_in = 4'h5; b_in = 4'h3;
        step();
        chk("col1_uo", uo_out, 8'hA9);
        r_in = 4'h0; g_in = 4'h0; b_in = 4'h0;
    endtask

    task automatic test_mid_reset();
        int n;
        wait_xy(4'd5, 4'd3);
        r_in = 4'hF; g_in = 4'hF; b_in = 4'hF;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        r_in = 4'h0; g_in = 4'h0; b_in = 4'h0;
        chk("mrst_x", {4'h0, x}, 8'h00);
        chk("mrst_y", {4'h0, y}, 8'h00);
        chk("mrst_uo", uo_out, 8'h88);
        chk("mrst_oe", uio_oe, 8'h00);
        n = 0;
        do begin
            step();
            n++;
        end while (!frame_start && n < 300);
        chk("mrst_frame_len", 8'(n), 8'd128);
    endtask

    initial begin
        rst_n = 1'b0; mode_in = 1'b0; mode2 = 1'b1;
        r_in = 4'h0; g_in = 4'h0; b_in = 4'h0;
        r2 = 2'b00; g2 = 2'b00; b2 = 2'b00;
        test_reset();
        test_counter_sweep();
        test_colour_mode0();
        test_depth();
        test_mode_switch();
        test_colour_mode1();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_pmod_timing.md
# vga_pmod_timing

Parametrised VGA timing generator and PMOD pin mapper for the TinyTapeout user wrapper. It generates the horizontal and vertical counters, blanking and syncs, then samples upstream pixel colour at a configurable depth. It drives either the 2-bit-per-channel single-PMOD pinout or the 4-bit Digilent dual-PMOD pinout. The pinout switch takes effect only at frame boundaries, so the image never tears.

## Interface
Parameters:
- H_VIS, 640: visible pixels per line
- H_FP, 16: horizontal front porch
- H_SYNC, 96: hsync width
- H_BP, 48: horizontal back porch
- V_VIS, 480: visible lines
- V_FP, 10: vertical front porch
- V_SYNC, 2: vsync width
- V_BP, 33: vertical back porch
- SYNC_POL, 0: sync active level (0 = active-low)
- CBITS, 4: colour bits per channel, legal 1..4
- CW, 10: counter width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  synchronous active-low reset
- mode_in  in  1  pinout request: 1 = single-PMOD 2-bit, 0 = Digilent 4-bit
- r_in, g_in, b_in  in  CBITS each  colour for the current x, y
- x  out  CW  current horizontal count
- y  out  CW  current vertical count
- de  out  1  x < H_VIS and y < V_VIS
- frame_start  out  1  one-cycle pulse while x = 0 and y = 0
- uo_out  out  8  dedicated output pins
- uio_out  out  8  bidirectional output path
- uio_oe  out  8  bidirectional enables

## Operation
- H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP. V_TOTAL is defined the same way.
- Horizontal counter h: runs 0..H_TOTAL-1, then wraps to 0.
- Vertical counter v: increments when h wraps. v wraps V_TOTAL-1 to 0 on the same cycle h wraps.
- x = h and y = v, combinational from the registers. de and frame_start are combinational from h and v.
- hs_raw is active for h in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC).
- vs_raw is active for v in [V_VIS+V_FP, V_VIS+V_FP+V_SYNC) and covers whole lines.
- Active level = SYNC_POL; inactive level = ~SYNC_POL.
- Colour stage:
  - Internal R, G, B are each 4 bits. The CBITS input is left-justified and its MSBs are replicated into the low bits (e.g. CBITS=2, r_in=2'b10 gives 4'b1010).
  - Values are forced to 0 when de = 0.
- Output stage: one register stage holds R4, G4, B4, hs and vs.
- Mode register mode_r:
  - Loaded from mode_in while rst_n = 0.
  - Also loaded on the cycle where h = H_TOTAL-1 and v = V_TOTAL-1, so the new mode applies from the first pixel of the next frame.
  - mode_in changes at any other time are ignored.
- Pin mapping is combinational from the output-stage registers and mode_r. Let R1:R0 be R4[3:2], and likewise for G and B.
- mode_r = 1 (single PMOD):
  - uo_out = {hs, B0, G0, R0, vs, B1, G1, R1}, MSB first.
  - uio_out = 0, uio_oe = 8'h00.
- mode_r = 0 (Digilent):
  - uo_out = {B4[3:0], R4[3:0]}.
  - uio_out = {2'b00, vs, hs, G4[3:0]}.
  - uio_oe = 8'hFF.

## Timing
- Reset (rst_n low at a clk edge):
  - h, v = 0, so x = y = 0, de = 1 and frame_start = 1.
  - Output-stage colours = 0; hs and vs = inactive.
  - With SYNC_POL = 0, the pins read as follows:
    - mode_in = 1: uo_out = 8'h88, uio_out = 8'h00, uio_oe = 8'h00.
    - mode_in = 0: uo_out = 8'h00, uio_out = 8'h30, uio_oe = 8'hFF.
- First cycle after reset release: counters at (0,0). Counting resumes from there.
- Reset asserted mid-frame: counters return to 0 on that edge and outputs blank on that edge. There is no partial-line recovery.
- Latency:
  - Upstream must present r/g/b_in combinationally for x, y in cycle N.
  - Pins show that pixel in cycle N+1.
  - hs and vs on the pins correspond to the same h and v, so colour and syncs stay aligned.
- Mode change: the pins switch mapping at the first pixel of frame k+1. That is the cycle after mode_r loads, i.e. pin output for (0,0) of the new frame is still the previous frame's last output mapped in the new mode. All affected pixels are blanked, so nothing is visible.
- Simultaneous h wrap and v wrap: v goes to 0, not V_TOTAL.

## Test plan
Small parameters for all tests: H 8/2/3/3 (total 16), V 4/1/2/1 (total 8), CBITS=4, SYNC_POL=0; frame = 128 cycles.

- Reset values: hold rst_n = 0 with mode_in = 0 → uo_out = 00, uio_out = 30, uio_oe = FF, x = y = 0, frame_start = 1. Repeat with mode_in = 1 → uo_out = 88, uio_oe = 00.
- Counter sweep: release reset and run 128 cycles.
  - x runs 0..15 and y runs 0..7.
  - de is high exactly 32 cycles.
  - frame_start pulses at cycles 0 and 128.
  - Pin hs is low when h = 10..12 (seen one cycle later).
  - Pin vs is low across 32 cycles (lines 5–6).
- Colour path, mode 0: drive r=A, g=5, b=3 when x=2, y=1 → next cycle uo_out = 8'h3A, uio_out = 8'h35. At x = 9, the same inputs give uo_out = 0.
- Depth replication: CBITS=2 rebuild, mode 1, r_in = 2'b10, g_in = 2'b01, b_in = 2'b11 → uo_out bits {B0,G0,R0} = 1,1,0 and {B1,G1,R1} = 1,0,1. hs and vs are high outside the sync windows.
- Mode switch: toggle mode_in 0→1 at y = 2.
  - uio_oe stays FF until the frame-wrap cycle and reads 00 on the next cycle.
  - A 1→0→1 glitch inside a frame does not change mode_r.
- Mid-frame reset: assert rst_n = 0 for 1 cycle at x=5, y=3 → next cycle x = y = 0 and pins are blanked; the frame restarts cleanly.
